load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width; only 32 is supported.
REQ-003 SHALL have one clock and synchronous active-high reset: clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 req_valid  in  1  pipeline memory request present.
REQ-006 req_wen / req_ren  in  1 each  store / load request.
REQ-007 req_funct3  in  3  RV32I size/sign code.
REQ-008 req_addr  in  ADDR_W  byte address.
REQ-009 req_wdata  in  DATA_W  unaligned store data in the low bits.
REQ-010 req_ready  out  1  request can be accepted this cycle.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  DATA_W  extended load data.
REQ-013 busy  out  1  pipeline stall request.
REQ-014 mem_addy  out  ADDR_W, mem_datain  out  DATA_W, mem_wen  out  1, mem_ren  out  1, mem_byte_select_vector  out  4: data-memory controller request.
REQ-015 mem_nostall  in  1, mem_dataout  in  DATA_W: data-memory controller status and read data.
REQ-016 exc_valid  out  1, exc_addr  out  ADDR_W: misalignment trap pulse and faulting address.

Function
REQ-017 SHALL implement FSM IDLE, ACCESS, DONE; req_ready=1 only in IDLE; busy=1 in ACCESS and DONE.
REQ-018 IDLE: on req_valid with req_wen or req_ren, latch addr/wdata/funct3/op, go ACCESS; req_wen=req_ren=1 is a store; neither set means no transaction.
REQ-019 ACCESS: mem_ren or mem_wen asserted from latched op; mem_addy/mem_datain/byte vector stable from latched registers for the whole state.
REQ-020 ACCESS with mem_nostall=1: capture extended mem_dataout (loads), go DONE; mem_nostall=0: remain ACCESS, outputs unchanged.
REQ-021 DONE: rsp_valid=1 for exactly one cycle, rsp_rdata held until the next DONE, next state IDLE.
REQ-022 Hit latency: accept edge N, ACCESS cycle N+1, rsp_valid cycle N+2; each stall cycle adds one.
REQ-023 Byte vector: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-024 Store data replicated: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
REQ-025 Loads: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-026 funct3 011/110/111: accepted, no memory access, DONE next cycle with rsp_rdata=0.
REQ-027 mem_wen/mem_ren SHALL be 0 in IDLE and DONE.

Reset
REQ-028 On reset edge: state IDLE; rsp_valid, exc_valid, mem_wen, mem_ren=0; rsp_rdata, exc_addr, latched address/data=0; mid-operation transactions are dropped without response.

Configuration
REQ-029 With LSU_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 goes IDLE->DONE without memory access, DONE pulses exc_valid with exc_addr=req_addr, rsp_valid=0.
REQ-030 Without LSU_MISALIGN_TRAP_EN: misaligned address low bits are cleared to natural alignment, access proceeds normally, exc_valid/exc_addr tied 0.

Structure
REQ-031 Shared package lsu_pkg SHALL hold funct3 constants (LB..LHU, SB..SW) and the FSM state encoding.
REQ-032 Lane selection, byte vector, store replication and load extension SHALL sit in combinational sub-module lsu_align.

Verification
REQ-033 SB addr 0x103 wdata 0x000000A5, nostall=1 -> ACCESS: byte vector 4'b1000, mem_datain 0xA5A5A5A5; rsp_valid at N+2.
REQ-034 LH addr 0x202, mem_dataout 0x8001_1234 -> rsp_rdata 0xFFFF8001; LHU same -> 0x00008001.
REQ-035 LW with mem_nostall=0 for 3 ACCESS cycles -> mem_ren held, address stable, rsp_valid at N+5.
REQ-036 LW addr 0x101 with macro -> exc_valid pulse, exc_addr 0x101, mem_ren never 1; without macro -> mem_addy 0x100.
REQ-037 Reset asserted during ACCESS stall -> next cycle IDLE, mem_ren=0, req_ready=1, no rsp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state encoding and alignment helpers for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic logic f3_is_nop(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Low address bits forced to the natural alignment of the access size.
  function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return {lo[1], 1'b0};
      2'b10:   return 2'b00;
      default: return lo;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return align_lo(f3, lo) != lo;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - pipeline request/response, data-memory and trap signals of the load/store unit
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_wen;
  logic              req_ren;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic [ADDR_W-1:0] mem_addy;
  logic [DATA_W-1:0] mem_datain;
  logic              mem_wen;
  logic              mem_ren;
  logic [3:0]        mem_byte_select_vector;
  logic              mem_nostall;
  logic [DATA_W-1:0] mem_dataout;
  logic              exc_valid;
  logic [ADDR_W-1:0] exc_addr;

  modport slave (
    input  req_valid, req_wen, req_ren, req_funct3, req_addr, req_wdata,
    input  mem_nostall, mem_dataout,
    output req_ready, rsp_valid, rsp_rdata, busy,
    output mem_addy, mem_datain, mem_wen, mem_ren, mem_byte_select_vector,
    output exc_valid, exc_addr
  );

  modport master (
    output req_valid, req_wen, req_ren, req_funct3, req_addr, req_wdata,
    output mem_nostall, mem_dataout,
    input  req_ready, rsp_valid, rsp_rdata, busy,
    input  mem_addy, mem_datain, mem_wen, mem_ren, mem_byte_select_vector,
    input  exc_valid, exc_addr
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-enable generation, store replication and load lane extraction/extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_sel,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);
  logic [15:0] lane_bits;

  assign lane_bits = 16'(rdata >> {lane, 3'b000});

  always_comb begin
    byte_sel   = 4'b1111;
    store_data = wdata;
    load_data  = rdata;
    case (funct3[1:0])
      2'b00: begin
        byte_sel   = 4'b0001 << lane;
        store_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        byte_sel   = 4'b0011 << {lane[1], 1'b0};
        store_data = {2{wdata[15:0]}};
      end
      default: ;
    endcase
    case (funct3)
      F3_LB:   load_data = {{24{lane_bits[7]}}, lane_bits[7:0]};
      F3_LH:   load_data = {{16{lane_bits[15]}}, lane_bits};
      F3_LBU:  load_data = {24'h0, lane_bits[7:0]};
      F3_LHU:  load_data = {16'h0, lane_bits};
      default: ;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - IDLE/ACCESS/DONE load/store sequencer; LSU_MISALIGN_TRAP_EN enables misalignment traps
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);
  state_t            state, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, load_data, store_data;
  logic [2:0]        funct3_q;
  logic [3:0]        byte_sel;
  logic              store_q, accept, nop_req, trap_req, exc_q;
  logic              fsm_ready, fsm_busy, fsm_ren, fsm_wen, fsm_rsp, fsm_exc;

  assign accept  = (state == ST_IDLE) && bus.req_valid && (bus.req_wen || bus.req_ren);
  assign nop_req = f3_is_nop(bus.req_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  logic [ADDR_W-1:0] exc_addr_q;

  assign trap_req = misaligned(bus.req_funct3, bus.req_addr[1:0]) && !nop_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      exc_q      <= 1'b0;
      exc_addr_q <= '0;
    end else if (accept) begin
      exc_q <= trap_req;
      if (trap_req) exc_addr_q <= bus.req_addr;
    end
  end

  assign bus.exc_addr = exc_addr_q;
`else
  assign trap_req     = 1'b0;
  assign exc_q        = 1'b0;
  assign bus.exc_addr = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  // Misaligned addresses are stored already aligned, so the access cycle never sees stray low bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      rdata_q  <= '0;
    end else if (accept) begin
      addr_q   <= {bus.req_addr[ADDR_W-1:2], align_lo(bus.req_funct3, bus.req_addr[1:0])};
      wdata_q  <= bus.req_wdata;
      funct3_q <= bus.req_funct3;
      store_q  <= bus.req_wen;
      if (nop_req) rdata_q <= '0;
    end else if (state == ST_ACCESS && bus.mem_nostall && !store_q) begin
      rdata_q <= load_data;
    end
  end

  always_comb begin
    state_d   = state;
    fsm_ready = 1'b0;
    fsm_busy  = 1'b0;
    fsm_ren   = 1'b0;
    fsm_wen   = 1'b0;
    fsm_rsp   = 1'b0;
    fsm_exc   = 1'b0;
    case (state)
      ST_IDLE: begin
        fsm_ready = 1'b1;
        if (accept) state_d = (nop_req || trap_req) ? ST_DONE : ST_ACCESS;
      end
      ST_ACCESS: begin
        fsm_busy = 1'b1;
        fsm_wen  = store_q;
        fsm_ren  = !store_q;
        if (bus.mem_nostall) state_d = ST_DONE;
      end
      ST_DONE: begin
        fsm_busy = 1'b1;
        fsm_rsp  = !exc_q;
        fsm_exc  = exc_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  lsu_align u_align (
    .lane       (addr_q[1:0]),
    .funct3     (funct3_q),
    .wdata      (wdata_q),
    .rdata      (bus.mem_dataout),
    .byte_sel   (byte_sel),
    .store_data (store_data),
    .load_data  (load_data)
  );

  assign bus.req_ready              = fsm_ready;
  assign bus.busy                   = fsm_busy;
  assign bus.rsp_valid              = fsm_rsp;
  assign bus.rsp_rdata              = rdata_q;
  assign bus.exc_valid              = fsm_exc;
  assign bus.mem_addy               = addr_q;
  assign bus.mem_datain             = store_data;
  assign bus.mem_byte_select_vector = byte_sel;
  assign bus.mem_wen                = fsm_wen;
  assign bus.mem_ren                = fsm_ren;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - vector table, corner sequences and randomized model checks for load_store_unit
module tb_load_store_unit;

  typedef struct {
    logic        wen;
    logic        ren;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem;
    int          stalls;
    int          exp_lat;
    logic [31:0] exp_addr;
    logic [3:0]  exp_bv;
    logic [31:0] exp_datain;
    logic [31:0] exp_rdata;
    logic        exp_exc;
    logic [31:0] exp_exc_addr;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] held = 32'h0;

  load_store_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t row(input logic wen, input logic ren, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] mem, input int stalls, input int lat,
                               input logic [31:0] eaddr, input logic [3:0] bv,
                               input logic [31:0] din, input logic [31:0] rd);
    vec_t v;
    v.wen = wen; v.ren = ren; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.mem = mem;
    v.stalls = stalls; v.exp_lat = lat; v.exp_addr = eaddr; v.exp_bv = bv;
    v.exp_datain = din; v.exp_rdata = rd; v.exp_exc = 1'b0; v.exp_exc_addr = 32'h0;
    return v;
  endfunction

  // Reference behaviour from the size/sign rules using plain arithmetic.
  function automatic vec_t model(input logic wen, input logic ren, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] mem, input int stalls,
                                 input logic [31:0] prev_rdata);
    vec_t v;
    int bytes, lane;
    logic [31:0] eff, mask, val;
    bit nop, mis, trap;
    v = row(wen, ren, f3, addr, wdata, mem, stalls, 0, 32'h0, 4'h0, 32'h0, prev_rdata);
    nop   = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    bytes = 1 << f3[1:0];
    eff   = addr - (addr % bytes);
    mis   = (addr % bytes) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = mis && !nop;
`else
    trap = 1'b0;
`endif
    lane = int'(eff % 4);
    v.exp_addr = eff;
    if (!nop) v.exp_bv = 4'(((1 << bytes) - 1) << lane);
    if (bytes == 1)      v.exp_datain = {24'h0, wdata[7:0]} * 32'h01010101;
    else if (bytes == 2) v.exp_datain = {16'h0, wdata[15:0]} * 32'h00010001;
    else                 v.exp_datain = wdata;
    if (nop) begin
      v.exp_lat = 1;
      v.exp_rdata = 32'h0;
    end else if (trap) begin
      v.exp_lat = 1;
      v.exp_exc = 1'b1;
      v.exp_exc_addr = addr;
    end else begin
      v.exp_lat = stalls + 2;
      if (!wen) begin
        mask = (bytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * bytes)) - 1);
        val = (mem >> (8 * lane)) & mask;
        if (!f3[2] && bytes < 4 && val[8*bytes-1]) val = val | ~mask;
        v.exp_rdata = val;
      end
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int lat, acc;
    bit done, stable, hs_ok, rsp_seen, exc_seen;
    logic [31:0] a_addr, a_din, rd, ea;
    logic [3:0] a_bv;
    logic [1:0] a_op;
    lat = 0; acc = 0; done = 0; stable = 1; hs_ok = 1; rsp_seen = 0; exc_seen = 0;
    a_addr = 0; a_din = 0; a_bv = 0; a_op = 0; rd = 0; ea = 0;
    @(negedge clk);
    check({tag, "_idle"}, {bus.req_ready, bus.busy, bus.rsp_valid, bus.exc_valid, bus.mem_ren, bus.mem_wen},
          32'b100000);
    bus.req_valid = 1'b1; bus.req_wen = v.wen; bus.req_ren = v.ren; bus.req_funct3 = v.f3;
    bus.req_addr = v.addr; bus.req_wdata = v.wdata; bus.mem_dataout = v.mem;
    bus.mem_nostall = (v.stalls == 0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_ren = 1'b0;
    bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_funct3 = 3'($urandom);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!bus.busy || bus.req_ready) hs_ok = 0;
      if (bus.rsp_valid || bus.exc_valid) begin
        done = 1; rsp_seen = bus.rsp_valid; exc_seen = bus.exc_valid;
        rd = bus.rsp_rdata; ea = bus.exc_addr;
        if (bus.mem_ren || bus.mem_wen) hs_ok = 0;
      end else if (bus.mem_ren || bus.mem_wen) begin
        acc++;
        if (acc == 1) begin
          a_addr = bus.mem_addy; a_bv = bus.mem_byte_select_vector;
          a_din = bus.mem_datain; a_op = {bus.mem_wen, bus.mem_ren};
        end else if (a_addr !== bus.mem_addy || a_bv !== bus.mem_byte_select_vector ||
                     a_din !== bus.mem_datain || a_op !== {bus.mem_wen, bus.mem_ren}) begin
          stable = 0;
        end
        bus.mem_nostall = (acc > v.stalls);
      end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_lat"}, lat, v.exp_lat);
    check({tag, "_acc"}, acc, v.exp_lat - 1);
    check({tag, "_busy"}, 32'(hs_ok), 32'd1);
    check({tag, "_rspv"}, {rsp_seen, exc_seen}, {!v.exp_exc, v.exp_exc});
    check({tag, "_rdata"}, rd, v.exp_rdata);
    if (v.exp_exc) check({tag, "_exca"}, ea, v.exp_exc_addr);
    if (acc > 0) begin
      check({tag, "_addr"}, a_addr, v.exp_addr);
      check({tag, "_bv"}, 32'(a_bv), 32'(v.exp_bv));
      check({tag, "_op"}, 32'(a_op), {30'h0, v.wen, !v.wen});
      check({tag, "_stable"}, 32'(stable), 32'd1);
      if (v.wen) check({tag, "_din"}, a_din, v.exp_datain);
    end
    held = v.exp_rdata;
  endtask

  vec_t tbl[10];
  vec_t mv;

  initial begin
    bus.req_valid = 0; bus.req_wen = 0; bus.req_ren = 0; bus.req_funct3 = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.mem_nostall = 1; bus.mem_dataout = 0;

    tbl[0] = row(1, 0, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0, 2, 32'h103, 4'b1000, 32'hA5A5A5A5, 32'h0);
    tbl[1] = row(0, 1, 3'd1, 32'h202, 32'h0, 32'h80011234, 0, 2, 32'h202, 4'b1100, 32'h0, 32'hFFFF8001);
    tbl[2] = row(0, 1, 3'd5, 32'h202, 32'h0, 32'h80011234, 0, 2, 32'h202, 4'b1100, 32'h0, 32'h00008001);
    tbl[3] = row(0, 1, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 3, 5, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
    tbl[4] = row(0, 1, 3'd0, 32'h101, 32'h0, 32'h12348056, 0, 2, 32'h101, 4'b0010, 32'h0, 32'hFFFFFF80);
    tbl[5] = row(0, 1, 3'd4, 32'h103, 32'h0, 32'hF2345678, 0, 2, 32'h103, 4'b1000, 32'h0, 32'h000000F2);
    tbl[6] = row(1, 0, 3'd1, 32'h002, 32'h1234BEEF, 32'h0, 0, 2, 32'h002, 4'b1100, 32'hBEEFBEEF, 32'hF2);
    tbl[7] = row(1, 1, 3'd2, 32'h3FC, 32'hCAFEF00D, 32'h0, 1, 3, 32'h3FC, 4'b1111, 32'hCAFEF00D, 32'hF2);
    tbl[8] = row(0, 1, 3'd3, 32'h010, 32'h0, 32'hFFFFFFFF, 0, 1, 32'h0, 4'h0, 32'h0, 32'h0);
    tbl[9] = row(1, 0, 3'd7, 32'h014, 32'h55, 32'h0, 2, 1, 32'h0, 4'h0, 32'h0, 32'h0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs", {bus.req_ready, bus.busy, bus.rsp_valid, bus.exc_valid, bus.mem_ren, bus.mem_wen},
          32'b100000);
    check("rst_rdata", bus.rsp_rdata, 32'h0);
    check("rst_addr", bus.mem_addy, 32'h0);
    check("rst_exca", bus.exc_addr, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    mv = row(0, 1, 3'd2, 32'h101, 32'h0, 32'h11223344, 0, 2, 32'h100, 4'b1111, 32'h0, 32'h11223344);
`ifdef LSU_MISALIGN_TRAP_EN
    mv.exp_lat = 1; mv.exp_exc = 1'b1; mv.exp_exc_addr = 32'h101; mv.exp_rdata = held;
`endif
    run_vec(mv, "mis_lw");

    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_ren = 1'b0; bus.req_funct3 = 3'd2;
    repeat (2) @(negedge clk);
    check("notxn", {bus.req_ready, bus.busy, bus.mem_ren, bus.mem_wen}, 32'b1000);
    bus.req_valid = 1'b0;

    bus.req_valid = 1'b1; bus.req_ren = 1'b1; bus.req_funct3 = 3'd2; bus.req_addr = 32'h200;
    bus.mem_nostall = 1'b0; bus.mem_dataout = 32'h0BADF00D;
    @(posedge clk);
    #1 bus.req_valid = 1'b0; bus.req_ren = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_stall_ren", {bus.mem_ren, bus.busy}, 32'b11);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_outs", {bus.req_ready, bus.busy, bus.rsp_valid, bus.mem_ren}, 32'b1000);
    check("rst_mid_rdata", bus.rsp_rdata, 32'h0);
    reset = 1'b0; bus.mem_nostall = 1'b1;
    begin
      bit saw_rsp = 0;
      repeat (4) begin
        @(negedge clk);
        if (bus.rsp_valid || bus.mem_ren) saw_rsp = 1;
      end
      check("rst_mid_norsp", 32'(saw_rsp), 32'd0);
    end
    held = 32'h0;

    for (int n = 0; n < 40; n++) begin
      logic w, r;
      int sel = $urandom_range(2, 0);
      w = (sel != 1);
      r = (sel != 0);
      mv = model(w, r, 3'($urandom), $urandom, $urandom, $urandom, $urandom_range(3, 0), held);
      run_vec(mv, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
